// File: rtl/scan_addr_gen.sv
// Scan address generator for a 6-to-64 line decoder: walks a latched window
// first..last (mod 64), holding each index for dwell+1 cycles, single-pass or continuous.
module scan_addr_gen #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               hold,
  input  logic               cont,
  input  logic [5:0]         first,
  input  logic [5:0]         last,
  input  logic [DWELL_W-1:0] dwell,
  output logic [5:0]         addr_out,
  output logic               dec_en,
  output logic               line_strobe,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

  state_t             state_reg, state_next;
  logic [5:0]         first_reg, last_reg;
  logic [DWELL_W-1:0] dwell_reg;
  logic               cont_reg;
  logic [DWELL_W-1:0] cnt_reg, cnt_next;
  logic [5:0]         addr_reg, addr_next;
  logic               dec_en_reg, dec_en_next;
  logic               strobe_reg, strobe_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;

  logic go;
  logic index_end;
  logic at_last;

  assign go        = (state_reg == IDLE) && start && !stop;
  assign index_end = !hold && (cnt_reg == dwell_reg);
  assign at_last   = (addr_reg == last_reg);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (go) state_next = SCAN;
      SCAN: begin
        if (stop)                                     state_next = IDLE;
        else if (index_end && at_last && !cont_reg)   state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output and datapath next values; every output is registered below
  always_comb begin
    addr_next   = addr_reg;
    cnt_next    = cnt_reg;
    dec_en_next = 1'b0;
    strobe_next = 1'b0;
    done_next   = 1'b0;
    busy_next   = (state_next != IDLE);
    case (state_reg)
      IDLE: begin
        addr_next = 6'd0;
        cnt_next  = '0;
        if (go) begin
          addr_next   = first;
          dec_en_next = 1'b1;
          strobe_next = 1'b1;
        end
      end
      SCAN: begin
        if (stop) begin
          addr_next = 6'd0;
          cnt_next  = '0;
        end else if (hold) begin
          dec_en_next = 1'b1;
        end else if (index_end) begin
          cnt_next = '0;
          if (!at_last) begin
            addr_next   = addr_reg + 6'd1;
            dec_en_next = 1'b1;
            strobe_next = 1'b1;
          end else if (cont_reg) begin
            addr_next   = first_reg;
            dec_en_next = 1'b1;
            strobe_next = 1'b1;
          end else begin
            addr_next = 6'd0;
            done_next = 1'b1;
          end
        end else begin
          cnt_next    = cnt_reg + 1'b1;
          dec_en_next = 1'b1;
        end
      end
      DONE: begin
        addr_next = 6'd0;
        cnt_next  = '0;
      end
      default: begin
        addr_next = 6'd0;
        cnt_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg   <= 6'd0;
      cnt_reg    <= '0;
      dec_en_reg <= 1'b0;
      strobe_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      addr_reg   <= addr_next;
      cnt_reg    <= cnt_next;
      dec_en_reg <= dec_en_next;
      strobe_reg <= strobe_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  // Window fields are captured only on an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_reg <= 6'd0;
      last_reg  <= 6'd0;
      dwell_reg <= '0;
      cont_reg  <= 1'b0;
    end else if (go) begin
      first_reg <= first;
      last_reg  <= last;
      dwell_reg <= dwell;
      cont_reg  <= cont;
    end
  end

  assign addr_out    = addr_reg;
  assign dec_en      = dec_en_reg;
  assign line_strobe = strobe_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;

endmodule

// File: tb/tb_scan_addr_gen.sv
// Scoreboard bench for scan_addr_gen: expected per-cycle outputs are queued
// from the window description when a scan is launched and popped each cycle.
module tb_scan_addr_gen;

  logic       clk = 1'b0;
  logic       rst_n, start, stop, hold, cont;
  logic [5:0] first, last;
  logic [3:0] dwell;
  logic [5:0] addr_out;
  logic       dec_en, line_strobe, busy, done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [5:0] addr;
    logic       en;
    logic       stb;
    logic       dn;
    logic       bsy;
    logic       chk_addr;
  } exp_t;

  exp_t exp_q[$];

  scan_addr_gen #(.DWELL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .hold(hold),
    .cont(cont), .first(first), .last(last), .dwell(dwell),
    .addr_out(addr_out), .dec_en(dec_en), .line_strobe(line_strobe),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic push(input logic [5:0] a, input logic en, input logic stb,
                      input logic dn, input logic bsy, input logic ca);
    exp_t e;
    e.addr = a; e.en = en; e.stb = stb; e.dn = dn; e.bsy = bsy; e.chk_addr = ca;
    exp_q.push_back(e);
  endtask

  // Launches one scan, builds its expected trace, and compares each cycle.
  task automatic run_scan(input string name, input logic [5:0] f, input logic [5:0] l,
                          input logic [3:0] dw, input logic c, input int passes,
                          input int hold_at, input int hold_len, input int stop_at);
    logic [5:0] span;
    logic [5:0] a;
    int n, k, c_idx;
    exp_t e;
    span = l - f;
    n = int'(span) + 1;
    k = 0;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < n; i++)
        for (int d = 0; d <= int'(dw); d++) begin
          a = f + 6'(i);
          push(a, 1'b1, (d == 0), 1'b0, 1'b1, 1'b1);
          if (k == hold_at)
            for (int h = 0; h < hold_len; h++) push(a, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
          k++;
        end
    if (stop_at >= 0) push(6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    else              push(6'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    push(6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    first = f; last = l; dwell = dw; cont = c; start = 1'b1;
    c_idx = 0;
    while (exp_q.size() > 0 && c_idx < 300) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      // scrambled window inputs must not affect a running scan
      first = ~f; last = ~l; dwell = ~dw; cont = ~c;
      e = exp_q.pop_front();
      $display("%s cyc %0d: addr=%0d en=%0b stb=%0b done=%0b busy=%0b", name, c_idx,
               addr_out, dec_en, line_strobe, done, busy);
      check({name, ".en"},   32'(dec_en),      32'(e.en));
      check({name, ".stb"},  32'(line_strobe), 32'(e.stb));
      check({name, ".done"}, 32'(done),        32'(e.dn));
      check({name, ".busy"}, 32'(busy),        32'(e.bsy));
      if (e.chk_addr) check({name, ".addr"}, 32'(addr_out), 32'(e.addr));
      if (c_idx == hold_at) hold = 1'b1;
      if (c_idx == hold_at + hold_len) hold = 1'b0;
      stop = (c_idx == stop_at);
      c_idx++;
    end
    stop = 1'b0; hold = 1'b0; cont = 1'b0;
    check({name, ".drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0; cont = 1'b0;
    first = 6'd0; last = 6'd0; dwell = 4'd0;
    repeat (2) @(negedge clk);
    check("rst.addr", 32'(addr_out), 32'd0);
    check("rst.en",   32'(dec_en), 32'd0);
    check("rst.stb",  32'(line_strobe), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_scan("t1_basic",  6'd0,  6'd3,  4'd0, 1'b0, 1, -1, 0, -1);
    run_scan("t2_wrap",   6'd62, 6'd1,  4'd1, 1'b0, 1, -1, 0, -1);
    run_scan("t3_single", 6'd5,  6'd5,  4'd3, 1'b0, 1, -1, 0, -1);
    run_scan("t4_cont",   6'd10, 6'd11, 4'd0, 1'b1, 3, -1, 0, 5);
    run_scan("t5_hold",   6'd0,  6'd3,  4'd0, 1'b0, 1, 2, 3, -1);

    // asynchronous reset in the middle of a scan
    first = 6'd20; last = 6'd30; dwell = 4'd3; cont = 1'b0; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    check("t6_pre.en", 32'(dec_en), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("t6_reset: addr=%0d en=%0b stb=%0b done=%0b busy=%0b",
             addr_out, dec_en, line_strobe, done, busy);
    check("t6_rst.addr", 32'(addr_out), 32'd0);
    check("t6_rst.en",   32'(dec_en), 32'd0);
    check("t6_rst.busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // start and stop together in IDLE: no scan
    first = 6'd7; last = 6'd9; start = 1'b1; stop = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0; stop = 1'b0;
    $display("t6_startstop: en=%0b busy=%0b stb=%0b", dec_en, busy, line_strobe);
    check("t6_ss.en",   32'(dec_en), 32'd0);
    check("t6_ss.busy", 32'(busy), 32'd0);
    check("t6_ss.stb",  32'(line_strobe), 32'd0);
    @(posedge clk); @(negedge clk);
    check("t6_ss2.en",  32'(dec_en), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
